led_mode_controller: RTL and testbench

Owns the red LED (LEDR) and the user button on the iCEBreaker board. It replaces the direct button-to-LED wire with a sequenced controller. The raw button is synchronised and debounced, and each clean press advances the LED through four modes: OFF, ON, BLINK and DIM (PWM). The block sits between the board pins and the top level, and reports its current mode for other logic.

---
 rtl/led_mode_controller.sv | 163 ++++++++++++++++
 tb/tb_led_mode_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_controller.sv
// led_mode_controller
//   Owns the red LED and the user button. The raw button is synchronised,
//   debounced and edge-detected; every accepted press steps the LED through
//   OFF -> ON -> BLINK -> DIM -> OFF.
//
// Ports
//   clk     in   system clock (12 MHz board oscillator)
//   rst_n   in   asynchronous active-low reset
//   button  in   raw asynchronous button pin
//   LEDR    out  red LED drive, registered
//   mode    out  current mode: 0=OFF, 1=ON, 2=BLINK, 3=DIM
//   press   out  one-cycle pulse per accepted press
module led_mode_controller #(
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned BLINK_HALF_CYCLES = 3000000,
  parameter int unsigned PWM_BITS          = 8,
  parameter int unsigned DIM_DUTY          = 32,
  parameter bit          BTN_ACTIVE_LOW    = 1'b1,
  parameter bit          LED_ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  output logic       LEDR,
  output logic [1:0] mode,
  output logic       press
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BL_W = $clog2(BLINK_HALF_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_DIM   = 2'd3
  } mode_t;

  logic                btn_pressed;
  logic                btn_p0;
  logic                btn_p1;
  logic                stable_p2;
  logic                stable_p3;
  logic [DB_W-1:0]     db_cnt;
  mode_t               mode_q;
  logic [BL_W-1:0]     blink_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_lit;
  logic                led_on;

  // Normalise polarity so that pressed = 1 everywhere downstream.
  assign btn_pressed = button ^ BTN_ACTIVE_LOW;

  // Stage p0/p1: two-flop synchroniser, released level out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn_pressed;
      btn_p1 <= btn_p0;
    end
  end

  // Stage p2: debounce. The counter tallies consecutive disagreeing samples;
  // the level is accepted on the DEBOUNCE_CYCLES-th such sample, so any
  // agreement in between restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_p2 <= 1'b0;
      db_cnt    <= '0;
    end else if (btn_p1 == stable_p2) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable_p2 <= btn_p1;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Stage p3: rising-edge detect on the debounced level; press is registered
  // so it appears on the edge after the level rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_p3 <= 1'b0;
      press     <= 1'b0;
    end else begin
      stable_p3 <= stable_p2;
      press     <= stable_p2 & ~stable_p3;
    end
  end

  // Mode FSM plus the BLINK half-period timer. The timer only runs while the
  // FSM stays in BLINK; entering, leaving or being outside BLINK reloads it
  // to count 0 with the lit phase, so every BLINK entry starts lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= M_OFF;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (press) begin
        case (mode_q)
          M_OFF:   mode_q <= M_ON;
          M_ON:    mode_q <= M_BLINK;
          M_BLINK: mode_q <= M_DIM;
          M_DIM:   mode_q <= M_OFF;
          default: mode_q <= M_OFF;
        endcase
      end
      if ((mode_q == M_BLINK) && !press) begin
        if (blink_cnt == BL_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end
    end
  end

  // Free-running PWM counter for DIM; wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Unsigned 32-bit compare: DIM_DUTY of 0 is never lit, and a duty at or
  // above the period length is always lit.
  assign pwm_lit = (32'(pwm_cnt) < DIM_DUTY);

  always_comb begin
    led_on = 1'b0;
    case (mode_q)
      M_ON:    led_on = 1'b1;
      M_BLINK: led_on = blink_phase;
      M_DIM:   led_on = pwm_lit;
      default: led_on = 1'b0;
    endcase
  end

  // Output stage: LED drive registered, one edge behind mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LEDR <= LED_ACTIVE_LOW;
    end else begin
      LEDR <= led_on ^ LED_ACTIVE_LOW;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_controller.sv
module tb_led_mode_controller;

  localparam int D    = 4;
  localparam int H    = 5;
  localparam int PB   = 3;
  localparam int DUTY = 2;

  typedef struct packed {
    logic       press;
    logic [1:0] mode;
    logic       ledr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b1;
  logic       LEDR;
  logic [1:0] mode;
  logic       press;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int press_cnt = 0;

  exp_t exp_q[$];

  // Reference model state (reset values)
  int m_s1 = 0, m_s2 = 0, m_stable = 0, m_stable_d = 0, m_cnt = 0;
  int m_press = 0, m_mode = 0, m_bt = 0, m_pwm = 0, m_ledr = 1;

  led_mode_controller #(
    .DEBOUNCE_CYCLES  (D),
    .BLINK_HALF_CYCLES(H),
    .PWM_BITS         (PB),
    .DIM_DUTY         (DUTY),
    .BTN_ACTIVE_LOW   (1'b1),
    .LED_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .button(button),
    .LEDR  (LEDR),
    .mode  (mode),
    .press (press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) if (press) press_cnt++;

  // Behavioural model: advances on each edge, pushes the expected outputs.
  always @(posedge clk or negedge rst_n) begin
    int pin, led_on, n_mode, n_bt, n_stable, n_cnt, n_press;
    exp_t e;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_stable_d = 0; m_cnt = 0;
      m_press = 0; m_mode = 0; m_bt = 0; m_pwm = 0; m_ledr = 1;
      exp_q.delete();
    end else begin
      pin = (button == 1'b0) ? 1 : 0;
      led_on = (m_mode == 1) ||
               (m_mode == 2 && ((m_bt / H) % 2) == 0) ||
               (m_mode == 3 && m_pwm < DUTY) ? 1 : 0;
      n_mode = (m_press != 0) ? (m_mode + 1) % 4 : m_mode;
      n_bt = (m_mode == 2 && n_mode == 2) ? m_bt + 1 : 0;
      n_press = (m_stable != 0 && m_stable_d == 0) ? 1 : 0;
      n_stable = m_stable;
      if (m_s2 == m_stable) n_cnt = 0;
      else if (m_cnt + 1 == D) begin n_stable = m_s2; n_cnt = 0; end
      else n_cnt = m_cnt + 1;
      m_ledr = led_on ? 0 : 1;
      m_stable_d = m_stable;
      m_stable = n_stable;
      m_cnt = n_cnt;
      m_press = n_press;
      m_mode = n_mode;
      m_bt = n_bt;
      m_pwm = (m_pwm + 1) % (1 << PB);
      m_s2 = m_s1;
      m_s1 = pin;
      e.press = 1'(m_press);
      e.mode = 2'(m_mode);
      e.ledr = 1'(m_ledr);
      exp_q.push_back(e);
    end
  end

  // Scoreboard: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_press", int'(press), int'(e.press));
      chk("sb_mode", int'(mode), int'(e.mode));
      chk("sb_ledr", int'(LEDR), int'(e.ledr));
    end else begin
      chk("rst_press", int'(press), 0);
      chk("rst_mode", int'(mode), 0);
      chk("rst_ledr", int'(LEDR), 1);
    end
  end

  task automatic drive(input logic val, input int n);
    button = val;
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input int hold, input int rel);
    drive(1'b0, hold);
    drive(1'b1, rel);
  endtask

  task automatic count_lit(input int n, output int lit);
    lit = 0;
    repeat (n) begin
      @(negedge clk);
      if (LEDR == 1'b0) lit++;
    end
  endtask

  initial begin
    int pc0, e_edge, t_press, t_mode, t_led, lit;

    // Reset held while the button toggles
    rst_n = 1'b0;
    button = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      button = ~button;
    end
    @(negedge clk);
    button = 1'b1;
    rst_n = 1'b1;
    drive(1'b1, 3);

    // Bounce shorter than the debounce window
    pc0 = press_cnt;
    drive(1'b0, 3);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 15);
    chk("bounce_press", press_cnt - pc0, 0);
    chk("bounce_mode", int'(mode), 0);
    chk("bounce_ledr", int'(LEDR), 1);

    // Clean press held 30 cycles: latency check
    pc0 = press_cnt;
    t_press = -1; t_mode = -1; t_led = -1;
    button = 1'b0;
    e_edge = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (press && t_press < 0) t_press = cyc;
      if (mode == 2'd1 && t_mode < 0) t_mode = cyc;
      if (LEDR == 1'b0 && t_led < 0) t_led = cyc;
    end
    chk("press_latency", t_press, e_edge + 6);
    chk("mode_latency", t_mode, e_edge + 7);
    chk("ledr_latency", t_led, e_edge + 8);
    drive(1'b1, 20);
    chk("press_once", press_cnt - pc0, 1);
    chk("on_mode", int'(mode), 1);

    // BLINK
    press_btn(12, 12);
    chk("blink_mode", int'(mode), 2);
    count_lit(20, lit);
    chk("blink_lit", lit, 10);

    // DIM
    press_btn(12, 4);
    chk("dim_mode", int'(mode), 3);
    count_lit(16, lit);
    chk("dim_lit", lit, 4);

    // Wrap back to OFF
    press_btn(12, 12);
    chk("wrap_mode", int'(mode), 0);
    count_lit(10, lit);
    chk("wrap_lit", lit, 0);

    // Reset mid-BLINK with the button held
    press_btn(12, 12);
    press_btn(12, 12);
    chk("blink2_mode", int'(mode), 2);
    button = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_ledr", int'(LEDR), 1);
    chk("async_mode", int'(mode), 0);
    chk("async_press", int'(press), 0);
    repeat (2) @(negedge clk);
    button = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pc0 = press_cnt;
    drive(1'b1, 20);
    chk("post_rst_press", press_cnt - pc0, 0);
    chk("post_rst_mode", int'(mode), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
